// File: rtl/digital_tube_scan_driver.sv
// digital_tube_scan_driver: free-running double-dabble BCD converter feeding a 6-digit multiplexed common-anode 7-segment scan.
// Optional `LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module digital_tube_scan_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        display_enable,
  input  logic [19:0] display_num,
  output logic [7:0]  seg,
  output logic [5:0]  sel
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  typedef enum logic [1:0] {LOAD, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [19:0] bin;
  logic [23:0] bcd, bcd_adj, digits;
  logic [4:0] cnt;
  logic [DW-1:0] div;
  logic [2:0] idx;
  logic [3:0] cur;
  logic [5:0] blank;
  logic [7:0] seg_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt == 5'd19) ? DONE : SHIFT;
      default: state_nxt = LOAD;
    endcase
  end
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 6; i++)
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bin    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      digits <= '0;
    end else if (state == LOAD) begin
      bin <= (display_num > 20'd999999) ? 20'd999999 : display_num;
      bcd <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      {bcd, bin} <= {bcd_adj, bin} << 1;
      cnt        <= cnt + 5'd1;
    end else
      digits <= bcd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (!display_enable) begin
      div <= '0;
      idx <= '0;
    end else if (div == DW'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else
      div <= div + 1'b1;
  assign cur = digits[{idx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
  // a digit is blank when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    logic z;
    z = 1'b1;
    blank = '0;
    for (int i = 5; i > 0; i--) begin
      z = z && (digits[4*i +: 4] == 4'd0);
      blank[i] = z;
    end
  end
`else
  assign blank = '0;
`endif
  always_comb begin
    seg_nxt = 8'hFF;
    case (cur)
      4'd0: seg_nxt = 8'hC0;
      4'd1: seg_nxt = 8'hF9;
      4'd2: seg_nxt = 8'hA4;
      4'd3: seg_nxt = 8'hB0;
      4'd4: seg_nxt = 8'h99;
      4'd5: seg_nxt = 8'h92;
      4'd6: seg_nxt = 8'h82;
      4'd7: seg_nxt = 8'hF8;
      4'd8: seg_nxt = 8'h80;
      4'd9: seg_nxt = 8'h90;
      default: seg_nxt = 8'hFF;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg <= 8'hFF;
      sel <= 6'h3F;
    end else begin
      seg <= (!display_enable || blank[idx]) ? 8'hFF : seg_nxt;
      sel <= display_enable ? ~(6'd1 << idx) : 6'h3F;
    end
endmodule

// File: tb/tb_digital_tube_scan_driver.sv
// tb_digital_tube_scan_driver: directed checks of conversion, scan order, clamping, enable and reset behaviour (SCAN_DIV=4).
module tb_digital_tube_scan_driver;
  logic clk = 1'b0, rst_n = 1'b0, display_enable = 1'b0;
  logic [19:0] display_num = '0;
  logic [7:0] seg;
  logic [5:0] sel;
  int total = 0, bad = 0;
  logic [7:0] exp_seg [6];
  logic [5:0] exp_sel;
  logic [7:0] lz;
  bit ok;

  digital_tube_scan_driver #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .display_enable(display_enable),
    .display_num(display_num), .seg(seg), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // align to the first cycle of a frame (sel turning to 3E)
  task automatic sync_frame(output bit found);
    logic [5:0] prev;
    found = 1'b0;
    prev = sel;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel == 6'h3E && prev != 6'h3E) begin
        found = 1'b1;
        break;
      end
      prev = sel;
    end
  endtask

  task automatic test_reset;
    int loads [$];
    rst_n = 1'b0;
    display_enable = 1'b0;
    step(2);
    total += 4;
    if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=ff", seg); end
    if (sel !== 6'h3F) begin bad++; $display("FAIL reset_sel got=%h want=3f", sel); end
    if (dut.digits !== 24'h0) begin bad++; $display("FAIL reset_digits got=%h want=0", dut.digits); end
    if (dut.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dut.state); end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step(1);
      total++;
      if (seg !== 8'hFF || sel !== 6'h3F) begin
        bad++;
        $display("FAIL disabled_out cyc=%0d got seg=%h sel=%h want ff/3f", c, seg, sel);
      end
      if (dut.state == 2'd0) loads.push_back(c);
    end
    total++;
    if (loads.size() < 2 || loads[1] - loads[0] != 22) begin
      bad++;
      $display("FAIL fsm_period got loads=%0d want period 22", loads.size());
    end
  endtask

  task automatic test_scan;
    display_num = 20'd123456;
    display_enable = 1'b1;
    step(50);
    exp_seg = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    sync_frame(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL scan_sync got=timeout want=frame start"); end
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step(1);
      exp_sel = ~(6'd1 << (k / 4));
      total++;
      if (sel !== exp_sel || seg !== exp_seg[k/4]) begin
        bad++;
        $display("FAIL scan_123456 k=%0d got sel=%h seg=%h want sel=%h seg=%h", k, sel, seg, exp_sel, exp_seg[k/4]);
      end
    end
  endtask

  task automatic test_clamp;
    display_num = 20'hFFFFF;
    step(50);
    total++;
    if (dut.digits !== 24'h999999) begin bad++; $display("FAIL clamp_digits got=%h want=999999", dut.digits); end
    sync_frame(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL clamp_sync got=timeout want=frame start"); end
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step(1);
      exp_sel = ~(6'd1 << (k / 4));
      total++;
      if (sel !== exp_sel || seg !== 8'h90) begin
        bad++;
        $display("FAIL clamp_scan k=%0d got sel=%h seg=%h want sel=%h seg=90", k, sel, seg, exp_sel);
      end
    end
  endtask

  task automatic test_mid_change;
    display_num = 20'd111111;
    step(1);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dut.state == 2'd0) begin ok = 1'b1; break; end
      step(1);
    end
    step(5);
    display_num = 20'd222222;
    for (int i = 0; i < 30 && ok; i++) begin
      if (dut.state == 2'd2) break;
      step(1);
      if (i == 29) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL mid_sync got=timeout want=LOAD/DONE"); end
    step(1);
    total++;
    if (dut.digits !== 24'h111111) begin bad++; $display("FAIL mid_first got=%h want=111111", dut.digits); end
    step(21);
    total++;
    if (dut.digits !== 24'h111111) begin bad++; $display("FAIL mid_hold got=%h want=111111", dut.digits); end
    step(1);
    total++;
    if (dut.digits !== 24'h222222) begin bad++; $display("FAIL mid_second got=%h want=222222", dut.digits); end
  endtask

  task automatic test_enable;
    sync_frame(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL en_sync got=timeout want=frame start"); end
    step(5);
    display_enable = 1'b0;
    step(1);
    total++;
    if (seg !== 8'hFF || sel !== 6'h3F) begin bad++; $display("FAIL en_fall got seg=%h sel=%h want ff/3f", seg, sel); end
    step(3);
    total++;
    if (seg !== 8'hFF || sel !== 6'h3F) begin bad++; $display("FAIL en_off got seg=%h sel=%h want ff/3f", seg, sel); end
    display_enable = 1'b1;
    step(1);
    total++;
    if (sel !== 6'h3E || seg !== 8'hA4) begin bad++; $display("FAIL en_rise got sel=%h seg=%h want 3e/a4", sel, seg); end
    step(3);
    total++;
    if (sel !== 6'h3E) begin bad++; $display("FAIL en_dwell got sel=%h want 3e", sel); end
    step(1);
    total++;
    if (sel !== 6'h3D || seg !== 8'hA4) begin bad++; $display("FAIL en_next got sel=%h seg=%h want 3d/a4", sel, seg); end
  endtask

  task automatic test_blank;
`ifdef LEADING_ZERO_BLANK_EN
    lz = 8'hFF;
`else
    lz = 8'hC0;
`endif
    display_num = 20'd42;
    step(50);
    exp_seg = '{8'hA4, 8'h99, lz, lz, lz, lz};
    sync_frame(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL blank42_sync got=timeout want=frame start"); end
    for (int k = 0; k < 24; k += 4) begin
      if (k > 0) step(4);
      exp_sel = ~(6'd1 << (k / 4));
      total++;
      if (sel !== exp_sel || seg !== exp_seg[k/4]) begin
        bad++;
        $display("FAIL blank_42 d=%0d got sel=%h seg=%h want sel=%h seg=%h", k/4, sel, seg, exp_sel, exp_seg[k/4]);
      end
    end
    display_num = 20'd0;
    step(50);
    exp_seg = '{8'hC0, lz, lz, lz, lz, lz};
    sync_frame(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL blank0_sync got=timeout want=frame start"); end
    for (int k = 0; k < 24; k += 4) begin
      if (k > 0) step(4);
      exp_sel = ~(6'd1 << (k / 4));
      total++;
      if (sel !== exp_sel || seg !== exp_seg[k/4]) begin
        bad++;
        $display("FAIL blank_0 d=%0d got sel=%h seg=%h want sel=%h seg=%h", k/4, sel, seg, exp_sel, exp_seg[k/4]);
      end
    end
  endtask

  task automatic test_async_reset;
    display_num = 20'd123456;
    step(50);
    step(7);
    #2 rst_n = 1'b0;
    #1;
    total += 4;
    if (seg !== 8'hFF || sel !== 6'h3F) begin bad++; $display("FAIL areset_out got seg=%h sel=%h want ff/3f", seg, sel); end
    if (dut.digits !== 24'h0) begin bad++; $display("FAIL areset_digits got=%h want=0", dut.digits); end
    if (dut.state !== 2'd0) begin bad++; $display("FAIL areset_state got=%0d want=0", dut.state); end
    if (dut.idx !== 3'd0 || dut.div !== '0) begin bad++; $display("FAIL areset_scan got idx=%0d div=%0d want 0/0", dut.idx, dut.div); end
    step(1);
    rst_n = 1'b1;
    step(1);
    total++;
    if (sel !== 6'h3E || seg !== 8'hC0) begin bad++; $display("FAIL areset_restart got sel=%h seg=%h want 3e/c0", sel, seg); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_clamp();
    test_mid_change();
    test_enable();
    test_blank();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
